// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus of the two-port memory arbiter.
// slave: arbiter view; master: requester/memory environment view.
interface mem_arbiter_if;
  localparam int unsigned N_REQ = 2;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = 4;

  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] addr;
  logic [N_REQ*DW-1:0] wdata;
  logic [N_REQ-1:0]    write;
  logic [N_REQ*SW-1:0] size;
  logic [DW-1:0]       rdata;
  logic [N_REQ-1:0]    done;
  logic [N_REQ-1:0]    err;

  logic [DW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic                mem_read;
  logic                mem_write;
  logic [SW-1:0]       mem_size;
  logic                mem_addr_ready;
  logic                mem_data_ready;
  logic [DW-1:0]       mem_rdata;

  modport slave (
    input  req, addr, wdata, write, size, mem_data_ready, mem_rdata,
    output rdata, done, err, mem_addr, mem_wdata, mem_read, mem_write,
           mem_size, mem_addr_ready
  );

  modport master (
    output req, addr, wdata, write, size, mem_data_ready, mem_rdata,
    input  rdata, done, err, mem_addr, mem_wdata, mem_read, mem_write,
           mem_size, mem_addr_ready
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin CPU/DMA arbiter in front of a single memory port.
// Optional DATA-phase abort counter enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_arbiter_if.slave bus
);
  localparam int unsigned N_REQ = 2;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = 4;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_e;

  state_e           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             ptr_q, ptr_d;
  logic [DW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic             write_q, write_d;
  logic [SW-1:0]    size_q, size_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [N_REQ-1:0] err_q, err_d;
  logic             mem_addr_ready_q, mem_addr_ready_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;

  logic             sel_c;
  logic [DW-1:0]    sel_addr_c;
  logic [SW-1:0]    sel_size_c;
  logic             misaligned_c;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_c;
  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // TIMEOUT_CYCLES has no effect when the abort counter is compiled out
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  // Candidate requester: round-robin pointer breaks ties
  always_comb begin
    sel_c        = (bus.req == 2'b11) ? ptr_q : bus.req[1];
    sel_addr_c   = sel_c ? bus.addr[2*DW-1:DW] : bus.addr[DW-1:0];
    sel_size_c   = sel_c ? bus.size[2*SW-1:SW] : bus.size[SW-1:0];
    misaligned_c = ((sel_size_c == '0) && (sel_addr_c[1:0] != 2'b00)) ||
                   ((sel_size_c[1] | sel_size_c[0]) && (sel_addr_c[1:0] == 2'b11));
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    done_d  = '0;
    err_d   = '0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req != '0) begin
          gnt_d   = sel_c;
          addr_d  = sel_addr_c;
          wdata_d = sel_c ? bus.wdata[2*DW-1:DW] : bus.wdata[DW-1:0];
          write_d = bus.write[sel_c];
          size_d  = sel_size_c;
          state_d = misaligned_c ? ERR : ADDR;
        end
      end
      ADDR: begin
        state_d = DATA;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      DATA: begin
        // A memory completion wins over a same-cycle timeout
        if (bus.mem_data_ready) begin
          rdata_d = bus.mem_rdata;
          done_d  = N_REQ'(1) << gnt_q;
          ptr_d   = ~gnt_q;
          state_d = IDLE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (timeout_c) begin
          done_d  = N_REQ'(1) << gnt_q;
          err_d   = N_REQ'(1) << gnt_q;
          ptr_d   = ~gnt_q;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
`endif
      end
      ERR: begin
        done_d  = N_REQ'(1) << gnt_q;
        err_d   = N_REQ'(1) << gnt_q;
        ptr_d   = ~gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    mem_addr_ready_d = (state_d == ADDR) || (state_d == DATA);
    mem_read_d       = mem_addr_ready_d & ~write_d;
    mem_write_d      = mem_addr_ready_d & write_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      gnt_q            <= 1'b0;
      ptr_q            <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      write_q          <= 1'b0;
      size_q           <= '0;
      rdata_q          <= '0;
      done_q           <= '0;
      err_q            <= '0;
      mem_addr_ready_q <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q            <= '0;
`endif
    end else begin
      state_q          <= state_d;
      gnt_q            <= gnt_d;
      ptr_q            <= ptr_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      write_q          <= write_d;
      size_q           <= size_d;
      rdata_q          <= rdata_d;
      done_q           <= done_d;
      err_q            <= err_d;
      mem_addr_ready_q <= mem_addr_ready_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q            <= cnt_d;
`endif
    end
  end

  assign bus.rdata          = rdata_q;
  assign bus.done           = done_q;
  assign bus.err            = err_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_size       = size_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_addr_ready = mem_addr_ready_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expectations queued at stimulus time,
// popped when done pulses; a small memory model answers memory cycles.
module tb_mem_arbiter;
  localparam int unsigned TO = 8;

  typedef struct {
    logic [1:0]  done;
    logic [1:0]  err;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [3:0]  size;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t exp_q[$];
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   done_cnt   = 0;
  int   mem_lat    = 1;
  bit   mem_silent = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic [31:0] a, input logic [31:0] wd,
                          input logic wr, input logic [3:0] sz, input logic [31:0] rd,
                          input logic is_err);
    exp_t e;
    e.done  = 2'(1) << id;
    e.err   = is_err ? e.done : 2'b00;
    e.addr  = a;
    e.wdata = wd;
    e.wr    = wr;
    e.size  = sz;
    e.rdata = rd;
    exp_q.push_back(e);
  endtask

  task automatic set_fields(input int id, input logic [31:0] a, input logic [31:0] wd,
                            input logic wr, input logic [3:0] sz);
    bus.addr[id*32 +: 32]  = a;
    bus.wdata[id*32 +: 32] = wd;
    bus.write[id]          = wr;
    bus.size[id*4 +: 4]    = sz;
  endtask

  task automatic wait_dones(input int target, input int budget, output int waited);
    waited = 0;
    while (done_cnt < target && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (done_cnt < target) check_eq("done_wait", 32'(done_cnt), 32'(target));
  endtask

  // One isolated request pulsed for a single cycle from an idle arbiter
  task automatic single(input string tag, input int id, input logic [31:0] a,
                        input logic [31:0] wd, input logic wr, input logic [3:0] sz,
                        input logic [31:0] rd, input int lat, input logic is_err);
    int base;
    int w;
    mem_lat = lat;
    set_fields(id, a, wd, wr, sz);
    push_exp(id, a, wd, wr, sz, rd, is_err);
    base = done_cnt;
    bus.req = 2'(1) << id;
    @(negedge clk);
    bus.req = '0;
    check_eq({tag, "_addr_ready"}, 32'(bus.mem_addr_ready), 32'(!is_err));
    wait_dones(base + 1, 40, w);
    check_eq({tag, "_latency"}, 32'(w + 1), is_err ? 32'd2 : 32'(lat + 2));
    check_eq({tag, "_idle_strobes"},
             32'({bus.mem_addr_ready, bus.mem_read, bus.mem_write}), 32'd0);
    @(negedge clk);
  endtask

  // Completion monitor: pops the scoreboard on every done pulse
  exp_t mon_e;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset_n === 1'b1 && bus.done != 2'b00) begin
        check_eq("done_onehot", 32'($onehot(bus.done)), 32'd1);
        if (exp_q.size() == 0) begin
          check_eq("spurious_done", 32'(bus.done), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("done", 32'(bus.done), 32'(mon_e.done));
          check_eq("err", 32'(bus.err), 32'(mon_e.err));
          if (mon_e.err == 2'b00) check_eq("rdata", bus.rdata, mon_e.rdata);
        end
        done_cnt++;
      end
    end
  end

  // Memory model: checks the command when it appears, answers after mem_lat cycles
  exp_t mem_e;
  bit   mem_busy = 1'b0;
  int   mem_wait = 0;
  initial begin
    bus.mem_data_ready = 1'b0;
    bus.mem_rdata      = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_data_ready) begin
        bus.mem_data_ready = 1'b0;
        mem_busy = 1'b0;
      end else if (bus.mem_addr_ready) begin
        if (!mem_busy) begin
          mem_busy = 1'b1;
          mem_wait = 0;
          check_eq("mem_cycle_sb", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            mem_e = exp_q[0];
            check_eq("mem_cycle_allowed", 32'(mem_e.err), 32'd0);
            check_eq("mem_addr", bus.mem_addr, mem_e.addr);
            check_eq("mem_size", 32'(bus.mem_size), 32'(mem_e.size));
            check_eq("mem_read", 32'(bus.mem_read), 32'(!mem_e.wr));
            check_eq("mem_write", 32'(bus.mem_write), 32'(mem_e.wr));
            if (mem_e.wr) check_eq("mem_wdata", bus.mem_wdata, mem_e.wdata);
          end
        end
        if (!mem_silent) begin
          if (mem_wait == mem_lat) begin
            bus.mem_data_ready = 1'b1;
            bus.mem_rdata      = (exp_q.size() != 0) ? exp_q[0].rdata : 32'h0;
          end else begin
            mem_wait++;
          end
        end
      end else begin
        mem_busy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int w;
    reset_n   = 1'b0;
    bus.req   = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.write = '0;
    bus.size  = '0;
    @(negedge clk);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_err", 32'(bus.err), 32'd0);
    check_eq("rst_rdata", bus.rdata, 32'd0);
    check_eq("rst_strobes", 32'({bus.mem_addr_ready, bus.mem_read, bus.mem_write}), 32'd0);

    // Both requesters held from reset: CPU, DMA, CPU, DMA
    set_fields(0, 32'h10, 32'h0, 1'b0, 4'b0000);
    set_fields(1, 32'h20, 32'h55AA55AA, 1'b1, 4'b0000);
    push_exp(0, 32'h10, 32'h0, 1'b0, 4'b0000, 32'h11110001, 1'b0);
    push_exp(1, 32'h20, 32'h55AA55AA, 1'b1, 4'b0000, 32'h22220002, 1'b0);
    push_exp(0, 32'h10, 32'h0, 1'b0, 4'b0000, 32'h11110003, 1'b0);
    push_exp(1, 32'h20, 32'h55AA55AA, 1'b1, 4'b0000, 32'h22220004, 1'b0);
    mem_lat = 1;
    bus.req = 2'b11;
    @(negedge clk);
    reset_n = 1'b1;
    wait_dones(4, 100, w);
    bus.req = '0;
    repeat (3) @(negedge clk);
    check_eq("rr_sb_drained", 32'(exp_q.size()), 32'd0);

    single("cpu_load", 0, 32'h100, 32'h0, 1'b0, 4'b0000, 32'hDEADBEEF, 2, 1'b0);
    single("dma_misalign", 1, 32'h202, 32'hCAFE0000, 1'b1, 4'b0000, 32'h0, 1, 1'b1);
    single("cpu_store", 0, 32'h40, 32'h12345678, 1'b1, 4'b0010, 32'h0BADF00D, 1, 1'b0);
    single("cpu_half_misalign", 0, 32'h43, 32'h0, 1'b0, 4'b0001, 32'h0, 1, 1'b1);
    single("dma_byte_odd", 1, 32'h303, 32'h0, 1'b0, 4'b1000, 32'h33330303, 3, 1'b0);
    single("cpu_half_ok", 0, 32'h42, 32'h0, 1'b0, 4'b0010, 32'h44440042, 1, 1'b0);

    // CPU request raised and dropped while DMA is busy: no CPU transaction
    mem_lat = 4;
    set_fields(1, 32'h500, 32'h0, 1'b0, 4'b0000);
    set_fields(0, 32'h504, 32'h0, 1'b0, 4'b0000);
    push_exp(1, 32'h500, 32'h0, 1'b0, 4'b0000, 32'h55550500, 1'b0);
    base = done_cnt;
    bus.req = 2'b10;
    @(negedge clk);
    bus.req = 2'b01;
    @(negedge clk);
    bus.req = '0;
    wait_dones(base + 1, 40, w);
    repeat (6) @(negedge clk);
    check_eq("dropped_req_no_txn", 32'(done_cnt), 32'(base + 1));

    // Leave the pointer on DMA, then abort a CPU load with reset in DATA
    single("cpu_pre_rst", 0, 32'h580, 32'h0, 1'b0, 4'b0000, 32'h58580580, 1, 1'b0);
    mem_lat = 6;
    set_fields(0, 32'h600, 32'h0, 1'b0, 4'b0000);
    push_exp(0, 32'h600, 32'h0, 1'b0, 4'b0000, 32'h66660600, 1'b0);
    base = done_cnt;
    bus.req = 2'b01;
    @(negedge clk);
    bus.req = '0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("rst_async_ready", 32'(bus.mem_addr_ready), 32'd0);
    check_eq("rst_async_rdata", bus.rdata, 32'd0);
    check_eq("rst_async_done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("rst_no_done", 32'(done_cnt), 32'(base));

    // Both pulse after reset: pointer back on CPU, DMA pulse dropped
    mem_lat = 1;
    set_fields(0, 32'h700, 32'h0, 1'b0, 4'b0000);
    set_fields(1, 32'h704, 32'h0, 1'b0, 4'b0000);
    push_exp(0, 32'h700, 32'h0, 1'b0, 4'b0000, 32'h77770700, 1'b0);
    bus.req = 2'b11;
    @(negedge clk);
    bus.req = '0;
    wait_dones(base + 1, 40, w);
    check_eq("post_rst_latency", 32'(w + 1), 32'd3);
    repeat (5) @(negedge clk);
    check_eq("post_rst_single", 32'(done_cnt), 32'(base + 1));

`ifdef MEM_ARB_TIMEOUT_EN
    // Silent memory: CPU aborts after TO DATA cycles, pending DMA follows
    mem_silent = 1'b1;
    set_fields(0, 32'h800, 32'h0, 1'b0, 4'b0000);
    set_fields(1, 32'h900, 32'h0, 1'b0, 4'b0000);
    push_exp(0, 32'h800, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1);
    push_exp(1, 32'h900, 32'h0, 1'b0, 4'b0000, 32'h99990900, 1'b0);
    base = done_cnt;
    mem_lat = 1;
    bus.req = 2'b01;
    @(negedge clk);
    bus.req = 2'b10;
    wait_dones(base + 1, 40, w);
    check_eq("timeout_latency", 32'(w + 1), 32'(TO + 2));
    mem_silent = 1'b0;
    wait_dones(base + 2, 40, w);
    bus.req = '0;
    repeat (3) @(negedge clk);
    check_eq("timeout_dma_next", 32'(done_cnt), 32'(base + 2));
`endif

    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: number of DATA-state cycles without mem_data_ready before abort; used only when MEM_ARB_TIMEOUT_EN is defined.
REQ-002 clk  in  1  single clock; all state SHALL change on posedge clk.
REQ-003 reset_n  in  1  reset, asynchronous and active-low.
REQ-004 req  in  2  request per requester; bit0 = CPU (instruction/load/store), bit1 = DMA.
REQ-005 addr  in  64  {DMA, CPU} 32-bit byte addresses.
REQ-006 wdata  in  64  {DMA, CPU} 32-bit store data.
REQ-007 write  in  2  per-requester direction; 1 = store, 0 = load.
REQ-008 size  in  8  {DMA, CPU} 4-bit size code, one-hot {byte, byte-unsigned, half, half-unsigned}; 0 = word.
REQ-009 rdata  out  32  load data; valid only in the cycle a done bit is high.
REQ-010 done  out  2  per-requester one-cycle completion pulse.
REQ-011 err  out  2  per-requester error flag; high only together with the matching done bit.
REQ-012 mem_addr, mem_wdata  out  32 each  memory address and store data.
REQ-013 mem_read, mem_write  out  1 each  memory direction strobes.
REQ-014 mem_size  out  4  size code forwarded to memory.
REQ-015 mem_addr_ready  out  1  address/command valid to memory.
REQ-016 mem_data_ready  in  1  memory completion.
REQ-017 mem_rdata  in  32  memory load data.

Function
REQ-018 The FSM SHALL have four states: IDLE, ADDR, DATA and ERR.
REQ-019 In IDLE with any req bit set, the block SHALL grant the requester selected as follows.
- One requester active: that requester is granted.
- Both active: the requester indicated by the round-robin pointer is granted.
REQ-020 At grant, the block SHALL register the granted requester's addr, wdata, write and size, then go to ADDR; it samples requester inputs only at grant.
REQ-021 If the granted request is misaligned, the block SHALL go to ERR instead and SHALL NOT issue a memory cycle.
- Misaligned: size==0 with addr[1:0]!=0, or a half-word size with addr[1:0]==3.
REQ-022 ADDR and DATA: mem_addr_ready SHALL be 1, mem_read SHALL be !write and mem_write SHALL be write; all mem_* strobes SHALL be 0 in IDLE and ERR.
REQ-023 ADDR SHALL last exactly one cycle, then go to DATA.
REQ-024 DATA SHALL wait for mem_data_ready=1; on that edge the block SHALL:
- capture mem_rdata into rdata;
- pulse the granted done bit for the next cycle;
- drop mem_addr_ready;
- set the pointer to the other requester;
- return to IDLE.
REQ-025 ERR SHALL pulse the granted done and err bits for one cycle, set the pointer to the other requester, and return to IDLE.
REQ-026 Latency: request accepted at edge N gives mem_addr_ready high from N+1; mem_data_ready sampled at edge M gives done high in cycle M+1.
REQ-027 Done and IDLE SHALL coincide, so consecutive grants are separated by at least one IDLE cycle.
REQ-028 Deassertion of req after grant SHALL be ignored; the transaction completes.
REQ-029 A req dropped before grant SHALL cause no transaction.
REQ-030 At most one done bit SHALL be high in any cycle.

Reset
REQ-031 While reset_n=0, the block SHALL force, asynchronously: state=IDLE, pointer=CPU, all outputs 0 (including rdata), timeout counter 0.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction with no done pulse.

Configuration
REQ-033 With MEM_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to DATA and increment each DATA cycle.
- On reaching TIMEOUT_CYCLES with mem_data_ready=0: mem_addr_ready drops, the granted done and err bits pulse, the pointer flips, and the FSM returns to IDLE.
- mem_data_ready=1 in that same cycle SHALL win, completing normally.
REQ-034 Without MEM_ARB_TIMEOUT_EN, DATA SHALL wait indefinitely and no counter logic SHALL exist.

Verification
REQ-035 CPU load only, addr=0x100, memory answers 2 cycles after mem_addr_ready -> mem_addr=0x100, mem_read=1, mem_rdata=0xDEADBEEF, done=01, rdata=0xDEADBEEF, err=00.
REQ-036 Both req held high from reset for 4 transactions -> grant order CPU, DMA, CPU, DMA; done alternates 01, 10, 01, 10.
REQ-037 DMA store addr=0x202, size=0 -> done=10, err=10, mem_addr_ready never 1.
REQ-038 CPU store addr=0x40, wdata=0x12345678, size=4'b0010, mem_data_ready after 1 cycle -> mem_write=1, mem_wdata=0x12345678, mem_size=0010, done=01.
REQ-039 reset_n pulled low in DATA, released; then CPU load -> no done for the aborted transfer; the new load completes normally with CPU granted first.
REQ-040 MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory silent -> done=01 and err=01 in the cycle after the 8th DATA cycle; the next pending DMA request is granted.
